// File: rtl/enigma_rotor_stack.sv
// enigma_rotor_stack: multi-rotor Enigma core with loadable wirings, odometer stepping and ready/valid handshakes
module enigma_rotor_stack #(
  parameter int NROT  = 3,
  parameter int ALPHA = 26,
  parameter int CW    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_rotor,
  input  logic [CW-1:0]      cfg_idx,
  input  logic [CW-1:0]      cfg_val,
  input  logic               pos_we,
  input  logic [1:0]         pos_rotor,
  input  logic [CW-1:0]      pos_val,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CW-1:0]      in_char,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CW-1:0]      out_char,
  output logic               out_err,
  output logic [NROT*CW-1:0] pos_out
);
  localparam logic [CW-1:0] AL    = CW'(ALPHA);
  localparam logic [CW-1:0] LASTC = CW'(ALPHA - 1);
  localparam logic [1:0]    LAST  = 2'(NROT - 1);
  localparam logic [2:0]    NR    = 3'(NROT);
  typedef enum logic [2:0] {IDLE, STEP, FWD, REFL, BWD, DONE} state_t;
  state_t        state;
  logic [1:0]    cnt;
  logic [CW-1:0] cur;
  logic          err;
  logic [CW-1:0] pos   [NROT];
  logic [CW-1:0] pos_n [NROT];
  logic [CW-1:0] w     [NROT][ALPHA];
  logic [CW-1:0] v     [NROT][ALPHA];
  logic [1:0]    rk;
  logic [CW-1:0] p, a, t, nxt;
  logic          carry;
  function automatic logic [CW-1:0] add26(input logic [CW-1:0] x, input logic [CW-1:0] y);
    logic [CW:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= {1'b0, AL}) ? CW'(s - {1'b0, AL}) : s[CW-1:0];
  endfunction
  function automatic logic [CW-1:0] sub26(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return (x >= y) ? x - y : x + AL - y;
  endfunction
  assign in_ready  = (state == IDLE) && !cfg_we && !pos_we;
  assign out_valid = (state == DONE);
  assign out_char  = cur;
  assign out_err   = err;
  for (genvar k = 0; k < NROT; k++) begin : g_pos
    assign pos_out[k*CW +: CW] = pos[k];
  end
  // Active-rotor mapping for the current pass and the odometer step of all positions
  always_comb begin
    rk = (state == BWD) ? LAST - cnt : cnt;
    p = pos[rk];
    a = add26(cur, p);
    t = (state == BWD) ? v[rk][a] : w[rk][a];
    nxt = sub26(t, p);
    carry = 1'b1;
    for (int k = 0; k < NROT; k++) begin
      pos_n[k] = carry ? ((pos[k] == LASTC) ? '0 : pos[k] + CW'(1)) : pos[k];
      carry = carry && (pos[k] == LASTC);
    end
  end
  // Control FSM, datapath register, rotor positions and wiring tables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cur <= '0;
      err <= 1'b0;
      for (int k = 0; k < NROT; k++) begin
        pos[k] <= '0;
        for (int j = 0; j < ALPHA; j++) begin
          w[k][j] <= CW'(j);
          v[k][j] <= CW'(j);
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (cfg_we && {1'b0, cfg_rotor} < NR && cfg_idx < AL && cfg_val < AL) begin
            w[cfg_rotor][cfg_idx] <= cfg_val;
            v[cfg_rotor][cfg_val] <= cfg_idx;
          end
          if (pos_we && {1'b0, pos_rotor} < NR && pos_val < AL) pos[pos_rotor] <= pos_val;
          if (in_valid && in_ready) begin
            cur <= in_char;
            err <= (in_char >= AL);
            state <= STEP;
          end
        end
        STEP: begin
          if (!err) pos <= pos_n;
          cnt <= '0;
          state <= FWD;
        end
        FWD: begin
          if (!err) cur <= nxt;
          cnt <= (cnt == LAST) ? '0 : cnt + 2'd1;
          state <= (cnt == LAST) ? REFL : FWD;
        end
        REFL: begin
          if (!err) cur <= LASTC - cur;
          state <= BWD;
        end
        BWD: begin
          if (!err) cur <= nxt;
          cnt <= (cnt == LAST) ? '0 : cnt + 2'd1;
          state <= (cnt == LAST) ? DONE : BWD;
        end
        DONE: state <= out_ready ? IDLE : DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_enigma_rotor_stack.sv
// tb_enigma_rotor_stack: directed table-driven and sequence checks of the rotor stack
module tb_enigma_rotor_stack;
  logic        clk, rst;
  logic        cfg_we, pos_we, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [1:0]  cfg_rotor, pos_rotor;
  logic [4:0]  cfg_idx, cfg_val, pos_val, in_char, out_char;
  logic [14:0] pos_out;
  int ncmp = 0;
  int nerr = 0;
  enigma_rotor_stack dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_rotor(cfg_rotor), .cfg_idx(cfg_idx),
    .cfg_val(cfg_val), .pos_we(pos_we), .pos_rotor(pos_rotor), .pos_val(pos_val),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .out_valid(out_valid),
    .out_ready(out_ready), .out_char(out_char), .out_err(out_err), .pos_out(pos_out)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0]  p2, p1, p0, ch, oc;
    logic        oe;
    logic [14:0] pe;
  } vec_t;
  vec_t vt[7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("idle_timeout", 0, 1);
  endtask
  task automatic wr_cfg(input int r, input int i, input int val);
    wait_idle();
    cfg_we = 1; cfg_rotor = 2'(r); cfg_idx = 5'(i); cfg_val = 5'(val);
    @(posedge clk); #1 cfg_we = 0;
  endtask
  task automatic set_pos(input int r, input int val);
    wait_idle();
    pos_we = 1; pos_rotor = 2'(r); pos_val = 5'(val);
    @(posedge clk); #1 pos_we = 0;
  endtask
  task automatic set3(input int p2, input int p1, input int p0);
    set_pos(2, p2); set_pos(1, p1); set_pos(0, p0);
  endtask
  task automatic enc(input logic [4:0] ch, output logic [4:0] oc, output logic oe, output int lat);
    wait_idle();
    in_valid = 1; in_char = ch;
    @(posedge clk); #1 in_valid = 0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    oc = out_char; oe = out_err;
  endtask
  function automatic int fw(input int k, input int y);
    case (k)
      0: return (3 * y + 1) % 26;
      1: return (5 * y + 7) % 26;
      default: return (7 * y + 2) % 26;
    endcase
  endfunction
  function automatic int bw(input int k, input int y);
    for (int z = 0; z < 26; z++) if (fw(k, z) == y) return z;
    return 0;
  endfunction
  function automatic int model(input int ch, input int p0, input int p1, input int p2);
    int pp[3];
    int x;
    pp[0] = p0; pp[1] = p1; pp[2] = p2;
    x = ch;
    for (int k = 0; k < 3; k++) x = (fw(k, (x + pp[k]) % 26) - pp[k] + 26) % 26;
    x = 25 - x;
    for (int k = 2; k >= 0; k--) x = (bw(k, (x + pp[k]) % 26) - pp[k] + 26) % 26;
    return x;
  endfunction
  initial begin
    logic [4:0] oc, c;
    logic oe;
    int lat;
    int m0, m1, m2;
    vt[0] = '{p2:0,  p1:0,  p0:0,  ch:0,  oc:25, oe:0, pe:{5'd0, 5'd0,  5'd1}};
    vt[1] = '{p2:3,  p1:25, p0:25, ch:4,  oc:21, oe:0, pe:{5'd4, 5'd0,  5'd0}};
    vt[2] = '{p2:25, p1:25, p0:25, ch:10, oc:15, oe:0, pe:{5'd0, 5'd0,  5'd0}};
    vt[3] = '{p2:0,  p1:0,  p0:25, ch:13, oc:12, oe:0, pe:{5'd0, 5'd1,  5'd0}};
    vt[4] = '{p2:0,  p1:5,  p0:24, ch:25, oc:0,  oe:0, pe:{5'd0, 5'd5,  5'd25}};
    vt[5] = '{p2:1,  p1:2,  p0:3,  ch:27, oc:27, oe:1, pe:{5'd1, 5'd2,  5'd3}};
    vt[6] = '{p2:0,  p1:0,  p0:25, ch:31, oc:31, oe:1, pe:{5'd0, 5'd0,  5'd25}};
    rst = 1; cfg_we = 0; pos_we = 0; in_valid = 0; out_ready = 1;
    cfg_rotor = 0; cfg_idx = 0; cfg_val = 0; pos_rotor = 0; pos_val = 0; in_char = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_char", 32'(out_char), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_pos_out", 32'(pos_out), 0);
    for (int i = 0; i < 7; i++) begin
      set3(vt[i].p2, vt[i].p1, vt[i].p0);
      enc(vt[i].ch, oc, oe, lat);
      chk($sformatf("vec%0d_latency", i), lat, 8);
      chk($sformatf("vec%0d_out_char", i), 32'(oc), 32'(vt[i].oc));
      chk($sformatf("vec%0d_out_err", i), 32'(oe), 32'(vt[i].oe));
      chk($sformatf("vec%0d_pos_out", i), 32'(pos_out), 32'(vt[i].pe));
    end
    for (int k = 0; k < 3; k++)
      for (int x = 0; x < 26; x++) wr_cfg(k, x, fw(k, x));
    wr_cfg(1, 3, 26);
    wr_cfg(3, 0, 5);
    set3(5, 12, 20);
    enc(5'd7, c, oe, lat);
    chk("recip_enc", 32'(c), 32'(model(7, 21, 12, 5)));
    chk("recip_differs", 32'(c != 5'd7), 1);
    set3(5, 12, 20);
    enc(c, oc, oe, lat);
    chk("recip_dec", 32'(oc), 7);
    m0 = 21; m1 = 12; m2 = 5;
    for (int x = 0; x < 26; x++) begin
      m0 = (m0 + 1) % 26;
      if (m0 == 0) begin
        m1 = (m1 + 1) % 26;
        if (m1 == 0) m2 = (m2 + 1) % 26;
      end
      enc(5'(x), oc, oe, lat);
      chk($sformatf("sweep%0d_model", x), 32'(oc), 32'(model(x, m0, m1, m2)));
      chk($sformatf("sweep%0d_no_self", x), 32'(oc != 5'(x)), 1);
    end
    chk("sweep_pos_out", 32'(pos_out), 32'({5'(m2), 5'(m1), 5'(m0)}));
    set3(1, 2, 3);
    out_ready = 0;
    enc(5'd9, c, oe, lat);
    chk("bp_latency", lat, 8);
    chk("bp_out_char", 32'(c), 32'(model(9, 4, 2, 1)));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pos_we = (i == 2); pos_rotor = 0; pos_val = 9;
      chk($sformatf("bp%0d_out_valid", i), 32'(out_valid), 1);
      chk($sformatf("bp%0d_out_char", i), 32'(out_char), 32'(c));
      chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 0);
    end
    @(negedge clk) pos_we = 0;
    chk("bp_pos_ignored", 32'(pos_out), 32'({5'd1, 5'd2, 5'd4}));
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp_release", 32'(out_valid), 0);
    wait_idle();
    in_valid = 1; in_char = 5'd5;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_pos_out", 32'(pos_out), 0);
    @(negedge clk) rst = 0;
    enc(5'd0, oc, oe, lat);
    chk("postrst_latency", lat, 8);
    chk("postrst_out_char", 32'(oc), 25);
    chk("postrst_pos_out", 32'(pos_out), 32'({5'd0, 5'd0, 5'd1}));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
